// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: queues floor requests, sweeps in one direction while
// requests remain that way, and opens the door at each requested floor.
module elevator_scan_ctrl #(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned FLOOR_W       = 4,
  parameter int unsigned TRAVEL_CYCLES = 536870912,
  parameter int unsigned DOOR_CYCLES   = 536870912
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic                  req_reject
);

  localparam logic [31:0] TravelLast = 32'(TRAVEL_CYCLES - 1);
  localparam logic [31:0] DoorLast   = 32'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic [31:0]             timer_q, timer_d;
  logic                    last_up_q, last_up_d;
  logic [1:0]              dir_q;
  logic                    door_q, reject_q;

  logic                    req_legal;
  logic [NUM_FLOORS-1:0]   req_mask, set_mask, clr_mask, arrive_mask;
  logic [FLOOR_W-1:0]      next_floor;
  logic                    up_here, dn_here, moving_up;

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    floor_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (f == FLOOR_W'(i + 1)) floor_mask[i] = 1'b1;
    end
  endfunction

  function automatic logic has_above(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
    has_above = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (FLOOR_W'(i + 1) > f)) has_above = 1'b1;
    end
  endfunction

  function automatic logic has_below(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
    has_below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (FLOOR_W'(i + 1) < f)) has_below = 1'b1;
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    timer_d     = timer_q;
    last_up_d   = last_up_q;
    clr_mask    = '0;
    next_floor  = floor_q;
    arrive_mask = '0;
    moving_up   = (state_q == StMoveUp);
    up_here     = has_above(pend_q, floor_q);
    dn_here     = has_below(pend_q, floor_q);
    req_legal   = req_valid && (req_floor != '0) && (req_floor <= FLOOR_W'(NUM_FLOORS));
    req_mask    = req_legal ? floor_mask(req_floor) : '0;
    set_mask    = req_mask;

    unique case (state_q)
      StIdle: begin
        if ((pend_q & floor_mask(floor_q)) != '0) begin
          state_d  = StDoor;
          timer_d  = '0;
          clr_mask = floor_mask(floor_q);
        end else if (up_here && (last_up_q || !dn_here)) begin
          state_d   = StMoveUp;
          last_up_d = 1'b1;
          timer_d   = '0;
        end else if (dn_here) begin
          state_d   = StMoveDown;
          last_up_d = 1'b0;
          timer_d   = '0;
        end
      end
      StMoveUp, StMoveDown: begin
        if (timer_q == TravelLast) begin
          next_floor  = moving_up ? floor_q + 1'b1 : floor_q - 1'b1;
          arrive_mask = floor_mask(next_floor);
          floor_d     = next_floor;
          timer_d     = '0;
          // A request landing on the arrival edge is served by this door opening.
          if (((pend_q | req_mask) & arrive_mask) != '0) begin
            state_d  = StDoor;
            clr_mask = arrive_mask;
          end else if (moving_up ? has_above(pend_q, next_floor)
                                 : has_below(pend_q, next_floor)) begin
            state_d = state_q;
          end else if (moving_up ? has_below(pend_q, next_floor)
                                 : has_above(pend_q, next_floor)) begin
            state_d   = moving_up ? StMoveDown : StMoveUp;
            last_up_d = !moving_up;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StDoor: begin
        if (req_legal && (req_floor == floor_q)) begin
          timer_d  = '0;
          set_mask = '0;
        end else if (timer_q == DoorLast) begin
          timer_d = '0;
          if (last_up_q && up_here) begin
            state_d = StMoveUp;
          end else if (!last_up_q && dn_here) begin
            state_d = StMoveDown;
          end else if (up_here) begin
            state_d   = StMoveUp;
            last_up_d = 1'b1;
          end else if (dn_here) begin
            state_d   = StMoveDown;
            last_up_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= StIdle;
      floor_q   <= FLOOR_W'(1);
      pend_q    <= '0;
      timer_q   <= '0;
      last_up_q <= 1'b1;
      dir_q     <= 2'b00;
      door_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      last_up_q <= last_up_d;
      dir_q     <= (state_d == StMoveUp)   ? 2'b01 :
                   (state_d == StMoveDown) ? 2'b10 : 2'b00;
      door_q    <= (state_d == StDoor);
      reject_q  <= req_valid && !req_legal;
    end
  end

  assign current_floor = floor_q;
  assign pending       = pend_q;
  assign dir           = dir_q;
  assign door_open     = door_q;
  assign req_reject    = reject_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench: a floor/mode reference model queues the expected outputs for each cycle
// and an independent monitor compares them against the controller after every clock edge.
module tb_elevator_scan_ctrl;

  localparam int NF     = 4;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  localparam int MIdle = 0;
  localparam int MUp   = 1;
  localparam int MDown = 2;
  localparam int MDoor = 3;

  typedef struct packed {
    logic [3:0] floor;
    logic [3:0] pend;
    logic [1:0] dir;
    logic       door;
    logic       rej;
  } obs_t;

  logic       clk = 1'b0;
  logic       iRST = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'd0;
  logic [3:0] current_floor;
  logic [3:0] pending;
  logic [1:0] dir;
  logic       door_open;
  logic       req_reject;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model state
  int m_mode;
  int m_floor;
  int m_timer;
  bit m_last_up;
  bit m_pend [1:NF];

  elevator_scan_ctrl #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (4),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .iCLK         (clk),
    .iRST         (iRST),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .current_floor(current_floor),
    .pending      (pending),
    .dir          (dir),
    .door_open    (door_open),
    .req_reject   (req_reject)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    return {current_floor, pending, dir, door_open, req_reject};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got floor=%0d pend=%b dir=%b door=%b rej=%b, expected floor=%0d pend=%b dir=%b door=%b rej=%b",
                  name, $time, got.floor, got.pend, got.dir, got.door, got.rej,
                  want.floor, want.pend, want.dir, want.door, want.rej);
  endtask

  function automatic bit any_above(input int f);
    for (int i = f + 1; i <= NF; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input int f);
    for (int i = 1; i < f; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t model_obs(input bit rej);
    obs_t o;
    o.floor = 4'(m_floor);
    for (int i = 1; i <= NF; i++) o.pend[i-1] = m_pend[i];
    o.dir  = (m_mode == MUp) ? 2'b01 : (m_mode == MDown) ? 2'b10 : 2'b00;
    o.door = (m_mode == MDoor);
    o.rej  = rej;
    return o;
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_floor = 1; m_timer = 0; m_last_up = 1'b1;
    for (int i = 1; i <= NF; i++) m_pend[i] = 1'b0;
  endtask

  // Pick the sweep direction: keep the preferred way if anything lies that way, else turn.
  task automatic choose_dir(input bit prefer_up, output int mode, output bit last_up);
    bit up, dn;
    up = any_above(m_floor);
    dn = any_below(m_floor);
    mode = MIdle; last_up = m_last_up;
    if (up && (prefer_up || !dn)) begin mode = MUp; last_up = 1'b1; end
    else if (dn) begin mode = MDown; last_up = 1'b0; end
  endtask

  task automatic model_advance(input bit v, input int f);
    bit legal, add, rej, up;
    int n_mode, n_floor, n_timer, clr, nf;
    bit n_last;
    legal = v && f >= 1 && f <= NF;
    rej = v && !legal;
    add = legal;
    n_mode = m_mode; n_floor = m_floor; n_timer = m_timer; n_last = m_last_up; clr = 0;
    case (m_mode)
      MIdle: begin
        if (m_pend[m_floor]) begin n_mode = MDoor; n_timer = 0; clr = m_floor; end
        else begin choose_dir(m_last_up, n_mode, n_last); n_timer = 0; end
      end
      MUp, MDown: begin
        up = (m_mode == MUp);
        if (m_timer == TRAVEL - 1) begin
          nf = up ? m_floor + 1 : m_floor - 1;
          n_floor = nf; n_timer = 0;
          if (m_pend[nf] || (legal && f == nf)) begin n_mode = MDoor; clr = nf; end
          else if (up ? any_above(nf) : any_below(nf)) n_mode = m_mode;
          else if (up ? any_below(nf) : any_above(nf)) begin
            n_mode = up ? MDown : MUp; n_last = !up;
          end else n_mode = MIdle;
        end else n_timer = m_timer + 1;
      end
      default: begin
        if (legal && f == m_floor) begin n_timer = 0; add = 1'b0; end
        else if (m_timer == DOOR - 1) begin
          n_timer = 0;
          choose_dir(m_last_up, n_mode, n_last);
        end else n_timer = m_timer + 1;
      end
    endcase
    if (add) m_pend[f] = 1'b1;
    if (clr != 0) m_pend[clr] = 1'b0;
    m_mode = n_mode; m_floor = n_floor; m_timer = n_timer; m_last_up = n_last;
    exp_q.push_back(model_obs(rej));
  endtask

  // One clock of stimulus, driven on the falling edge; the model predicts the next edge.
  task automatic step(input bit r, input bit v, input int f);
    bit rising;
    @(negedge clk);
    rising = r && !iRST;
    iRST = r;
    req_valid = v;
    req_floor = 4'(f);
    if (r) begin
      if (rising) begin
        #1;
        check("async_reset", dut_obs(), {4'd1, 4'd0, 2'b00, 1'b0, 1'b0});
      end
      model_reset();
      exp_q.push_back(model_obs(1'b0));
    end else begin
      model_advance(v, f);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cycle", dut_obs(), e);
      end
    end
  end

  initial begin : stimulus
    int rst_cnt;
    model_reset();
    #2 iRST = 1'b1;
    #1 check("power_on_reset", dut_obs(), {4'd1, 4'd0, 2'b00, 1'b0, 1'b0});
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(3);

    // single trip up to floor 3
    step(1'b0, 1'b1, 3);
    idle(20);
    // illegal floors, including a duplicate-free idle car
    step(1'b0, 1'b1, 0);
    idle(1);
    step(1'b0, 1'b1, 5);
    idle(3);
    // back to 1, then 4 with a pickup at 2 on the way
    step(1'b0, 1'b1, 1);
    idle(15);
    step(1'b0, 1'b1, 4);
    idle(2);
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b1, 4);
    idle(40);
    // from 3 heading to 4 with floor 1 waiting behind
    step(1'b0, 1'b1, 3);
    idle(12);
    step(1'b0, 1'b1, 4);
    idle(1);
    step(1'b0, 1'b1, 1);
    idle(50);
    // re-request the open floor on the second door cycle
    step(1'b0, 1'b1, 2);
    for (int k = 0; k < 40 && !(m_mode == MDoor && m_timer == 1); k++) idle(1);
    step(1'b0, 1'b1, 2);
    idle(10);
    // reset in the middle of an upward move
    step(1'b0, 1'b1, 4);
    for (int k = 0; k < 40 && !(m_mode == MUp && m_timer == 2); k++) idle(1);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(10);

    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_cnt > 0) begin
        rst_cnt--;
        step(1'b1, 1'b0, 0);
      end else if ($urandom_range(0, 799) == 0) begin
        rst_cnt = 1;
        step(1'b1, 1'b0, 0);
      end else begin
        step(1'b0, $urandom_range(0, 5) == 0, int'($urandom_range(0, 5)));
      end
    end
    idle(3);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 4, number of served floors (legal 2..15), numbered 1..NUM_FLOORS.
REQ-002 SHALL have parameter FLOOR_W, default 4, floor-number width; 2^FLOOR_W > NUM_FLOORS.
REQ-003 SHALL have parameter TRAVEL_CYCLES, default 536870912, clock cycles to move one floor.
REQ-004 SHALL have parameter DOOR_CYCLES, default 536870912, clock cycles the door stays open.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 iCLK  in  1  system clock, all state on rising edge.
REQ-007 iRST  in  1  asynchronous active-high reset.
REQ-008 req_valid  in  1  one-cycle request strobe, synchronous to iCLK (debounced upstream).
REQ-009 req_floor  in  FLOOR_W  requested floor, sampled when req_valid=1.
REQ-010 current_floor  out  FLOOR_W  floor the car is at.
REQ-011 pending  out  NUM_FLOORS  outstanding requests; bit i = floor i+1.
REQ-012 dir  out  2  00 idle, 01 up, 10 down; 11 never driven.
REQ-013 door_open  out  1  high while in DOOR state.
REQ-014 req_reject  out  1  one-cycle pulse for an illegal request.

Function
REQ-015 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR, plus internal timer and last_dir register (up/down).
REQ-016 Request with 1<=req_floor<=NUM_FLOORS SHALL set its pending bit at the next edge; req_floor=0 or >NUM_FLOORS SHALL pulse req_reject the next cycle and change nothing else.
REQ-017 Request for current_floor while in DOOR SHALL restart the door timer to 0 and not set pending.
REQ-018 Duplicate request for an already-pending floor SHALL be harmless (bit stays set).
REQ-019 IDLE: pending=0 -> stay; pending bit of current_floor set -> DOOR next cycle, clearing that bit; else requests above only -> MOVE_UP; below only -> MOVE_DOWN; both -> continue last_dir.
REQ-020 MOVE_UP/MOVE_DOWN: timer counts 0..TRAVEL_CYCLES-1; on the cycle timer=TRAVEL_CYCLES-1, current_floor SHALL step +1/-1 at that edge and timer SHALL return to 0.
REQ-021 On arrival: new floor pending -> DOOR, clear bit same edge; else more requests in travel direction -> keep moving; else requests opposite -> reverse state; else IDLE.
REQ-022 current_floor SHALL never leave 1..NUM_FLOORS; a move state SHALL never be entered with no request in that direction.
REQ-023 DOOR: door_open=1 for exactly DOOR_CYCLES cycles (absent REQ-017 restarts), then direction choice per REQ-019 rule (continue last_dir if requests that way, else reverse, else IDLE); dir=00 while in DOOR.
REQ-024 last_dir SHALL update on every entry into MOVE_UP (up) or MOVE_DOWN (down).
REQ-025 Request arriving on the same edge as arrival at that floor SHALL be absorbed by the door opening, leaving its pending bit clear.
REQ-026 Request arriving on the same edge a bit is cleared for a different floor SHALL not be lost.
REQ-027 dir SHALL be 01 in MOVE_UP, 10 in MOVE_DOWN, 00 otherwise; all outputs registered.

Reset
REQ-028 iRST=1 SHALL immediately force: state IDLE, current_floor=1, pending=0, dir=00, door_open=0, req_reject=0, timer=0, last_dir=up.
REQ-029 Reset mid-travel or mid-door SHALL discard all pending requests; no step occurs after reset release until a new request.

Verification (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-030 Reset, request floor 3 -> pending=0100 next cycle, dir=01, floor 2 after 4 cycles, floor 3 after 8, door_open=1 for 3 cycles, pending=0000, then IDLE.
REQ-031 At floor 1 request 4, then request 2 during first travel -> stops at 2 (door 3 cycles), continues to 4; never reverses.
REQ-032 At floor 3 moving up to 4 with floor 1 pending -> door at 4, then dir=10, steps 4->3->2->1, door at 1.
REQ-033 req_floor=0 and req_floor=5 -> req_reject single pulse each, pending unchanged, state unchanged.
REQ-034 Door open at floor 2, re-request floor 2 on door cycle 2 -> door stays open 3 more cycles, pending bit never set.
REQ-035 Assert iRST during MOVE_UP timer=2 -> outputs at reset values asynchronously, car idle at floor 1 after release.
